// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer feeding the execute core.
//
// A `req` seen in IDLE loads `start_addr` into the program counter. The block
// then loops FETCH -> WAIT -> ISSUE: it reads one word from the synchronous
// instruction memory, captures it, and offers it to execute. When it reads
// HALT_WORD it pulses `ack` for one cycle in DONE and returns to IDLE.
//
// Handshake: `instr` is valid whenever `instr_valid` is 1 and is held stable
// until a cycle where `instr_valid` and `instr_ready` are both 1. That cycle
// is the only cycle in which `br_taken`/`br_target` are sampled.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   req, start_addr   start request (honoured only in IDLE) and first address
//   ack, busy         halt pulse, high in every state except IDLE
//   imem_addr/rd/data instruction memory: address, read strobe, data (+1 cycle)
//   instr, instr_valid, instr_ready   instruction handshake to execute
//   br_taken, br_target               branch result for the accepted instr
//   pc, issue_count   program counter, instructions issued since last `req`
//   state_dbg         current FSM state encoding, for observation only

module fetch_seq #(
    parameter int                   PC_W      = 8,
    parameter int                   INSTR_W   = 9,
    parameter logic [INSTR_W-1:0]   HALT_WORD = 9'h1FF,
    parameter int                   CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [PC_W-1:0]    start_addr,
    output logic               ack,
    output logic               busy,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   issue_count,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rd_q, valid_q, ack_q, busy_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    pc_d    = start_addr;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The halt word is captured like any other word but never offered.
                instr_d = imem_data;
                state_d = (imem_data == HALT_WORD) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    // Natural PC_W-bit arithmetic gives the wrap from all-ones to zero.
                    pc_d    = br_taken ? br_target : pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flags are registered from the next state so that every output
    // comes straight from a flop while still lining up with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            rd_q    <= (state_d == S_FETCH);
            valid_q <= (state_d == S_ISSUE);
            ack_q   <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign imem_addr   = pc_q;
    assign imem_rd     = rd_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign ack         = ack_q;
    assign busy        = busy_q;
    assign pc          = pc_q;
    assign issue_count = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

    localparam logic [8:0] HALT = 9'h1FF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic        ack;
    logic        busy;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [8:0]  imem_data = 9'h000;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic [7:0]  pc;
    logic [15:0] issue_count;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] rom [256];

    fetch_seq dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .start_addr  (start_addr),
        .ack         (ack),
        .busy        (busy),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .pc          (pc),
        .issue_count (issue_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= rom[imem_addr];
    end

    // ---------------- reference model ----------------
    // Tracks which step of the program walk the sequencer should be in and
    // what it should be showing, using the rules of the sequencer directly.
    logic       m_fetch = 1'b0, m_wait = 1'b0, m_issue = 1'b0, m_ack = 1'b0;
    logic [7:0] m_pc = 8'h00;
    logic [8:0] m_instr = 9'h000;
    logic [15:0] m_cnt = 16'h0000;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_fetch <= 1'b0; m_wait <= 1'b0; m_issue <= 1'b0; m_ack <= 1'b0;
            m_pc <= 8'h00; m_instr <= 9'h000; m_cnt <= 16'h0000;
        end else if (m_ack) begin
            m_ack <= 1'b0;
        end else if (m_fetch) begin
            m_fetch <= 1'b0;
            m_wait  <= 1'b1;
        end else if (m_wait) begin
            m_wait  <= 1'b0;
            m_instr <= rom[m_pc];
            if (rom[m_pc] == HALT) m_ack <= 1'b1;
            else                   m_issue <= 1'b1;
        end else if (m_issue) begin
            if (instr_ready) begin
                m_issue <= 1'b0;
                m_fetch <= 1'b1;
                m_cnt   <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
                m_pc    <= br_taken ? br_target : m_pc + 8'd1;
            end
        end else if (req) begin
            m_pc    <= start_addr;
            m_cnt   <= 16'h0000;
            m_fetch <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_imem_rd",     32'(imem_rd),     32'(m_fetch));
        chk("cmp_imem_addr",   32'(imem_addr),   32'(m_pc));
        chk("cmp_instr_valid", 32'(instr_valid), 32'(m_issue));
        if (m_issue) chk("cmp_instr", 32'(instr), 32'(m_instr));
        chk("cmp_ack",         32'(ack),         32'(m_ack));
        chk("cmp_busy",        32'(busy),        32'(m_fetch | m_wait | m_issue | m_ack));
        chk("cmp_pc",          32'(pc),          32'(m_pc));
        chk("cmp_issue_count", 32'(issue_count), 32'(m_cnt));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs a fixed window, counting ack pulses; the window bounds the wait.
    task automatic wait_ack(input int cycles, output int acks);
        acks = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (ack === 1'b1) acks++;
        end
    endtask

    // Start in IDLE; the caller's current cycle is cycle 0.
    task automatic basic_run(input string tag);
        instr_ready = 1'b1;
        req = 1'b1; start_addr = 8'h10;
        step();                                           // cycle 1
        req = 1'b0;
        chk({tag, "_c1_rd"},   32'(imem_rd),   32'd1);
        chk({tag, "_c1_addr"}, 32'(imem_addr), 32'h10);
        step();                                           // cycle 2
        chk({tag, "_c2_valid"}, 32'(instr_valid), 32'd0);
        step();                                           // cycle 3
        chk({tag, "_c3_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_c3_instr"}, 32'(instr),       32'h041);
        step();                                           // cycle 4
        chk({tag, "_c4_rd"},   32'(imem_rd),   32'd1);
        chk({tag, "_c4_addr"}, 32'(imem_addr), 32'h11);
        chk({tag, "_c4_ack"},  32'(ack),       32'd0);
        step();                                           // cycle 5
        chk({tag, "_c5_ack"},  32'(ack),       32'd0);
        step();                                           // cycle 6
        chk({tag, "_c6_ack"},  32'(ack),       32'd1);
        step();                                           // cycle 7
        chk({tag, "_c7_ack"},  32'(ack),         32'd0);
        chk({tag, "_c7_cnt"},  32'(issue_count), 32'd1);
        chk({tag, "_c7_pc"},   32'(pc),          32'h11);
        chk({tag, "_c7_busy"}, 32'(busy),        32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acks;
        for (int i = 0; i < 256; i++) rom[i] = 9'(i) ^ 9'h0AA;
        rom[8'h10] = 9'h041; rom[8'h11] = HALT;
        rom[8'h40] = 9'h055; rom[8'h41] = HALT;
        rom[8'h20] = 9'h123; rom[8'h05] = 9'h0C3; rom[8'h06] = HALT;
        rom[8'hFF] = 9'h011; rom[8'h00] = HALT;
        rom[8'h30] = HALT;

        #1 reset = 1'b0;
        #2;
        chk("rst_pc",    32'(pc),          32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr),       32'd0);
        chk("rst_cnt",   32'(issue_count), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        basic_run("basic");

        // Backpressure: four stalled ISSUE cycles.
        instr_ready = 1'b0;
        req = 1'b1; start_addr = 8'h40;
        step(); req = 1'b0;
        step(); step();                                   // cycle 3
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_instr", 32'(instr),       32'h055);
            chk("bp_pc",    32'(pc),          32'h40);
            chk("bp_rd",    32'(imem_rd),     32'd0);
            step();
        end
        instr_ready = 1'b1;                               // cycle 7
        chk("bp_c7_valid", 32'(instr_valid), 32'd1);
        step();                                           // cycle 8
        chk("bp_c8_rd",   32'(imem_rd),   32'd1);
        chk("bp_c8_addr", 32'(imem_addr), 32'h41);
        wait_ack(6, acks);
        chk("bp_acks", 32'(acks), 32'd1);

        // Branch: stalled br_taken ignored, handshake branch to 0x05.
        instr_ready = 1'b0;
        req = 1'b1; start_addr = 8'h20;
        step(); req = 1'b0;
        step(); step();                                   // cycle 3
        chk("br_c3_instr", 32'(instr), 32'h123);
        br_taken = 1'b1; br_target = 8'h33;
        step();                                           // cycle 4
        br_taken = 1'b0;
        chk("br_stall_pc",    32'(pc),          32'h20);
        chk("br_stall_rd",    32'(imem_rd),     32'd0);
        chk("br_stall_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1; br_taken = 1'b1; br_target = 8'h05;
        step();                                           // cycle 5
        br_taken = 1'b0; br_target = 8'h00;
        chk("br_rd",   32'(imem_rd),   32'd1);
        chk("br_addr", 32'(imem_addr), 32'h05);
        wait_ack(8, acks);
        chk("br_acks", 32'(acks),        32'd1);
        chk("br_pc",   32'(pc),          32'h06);
        chk("br_cnt",  32'(issue_count), 32'd2);

        // Wrap: 0xFF -> 0x00.
        instr_ready = 1'b1;
        req = 1'b1; start_addr = 8'hFF;
        step(); req = 1'b0;
        chk("wrap_c1_addr", 32'(imem_addr), 32'hFF);
        step(); step();                                   // cycle 3
        chk("wrap_instr", 32'(instr), 32'h011);
        step();                                           // cycle 4
        chk("wrap_rd",   32'(imem_rd),   32'd1);
        chk("wrap_addr", 32'(imem_addr), 32'h00);
        wait_ack(6, acks);
        chk("wrap_acks", 32'(acks), 32'd1);

        // Halt as the first word.
        req = 1'b1; start_addr = 8'h30;
        step(); req = 1'b0;
        chk("halt_c1_valid", 32'(instr_valid), 32'd0);
        step();
        chk("halt_c2_valid", 32'(instr_valid), 32'd0);
        step();                                           // cycle 3
        chk("halt_c3_ack",   32'(ack),         32'd1);
        chk("halt_c3_valid", 32'(instr_valid), 32'd0);
        step();                                           // cycle 4
        chk("halt_c4_ack",  32'(ack),         32'd0);
        chk("halt_c4_busy", 32'(busy),        32'd0);
        chk("halt_c4_cnt",  32'(issue_count), 32'd0);
        chk("halt_c4_pc",   32'(pc),          32'h30);

        // req during ISSUE is ignored.
        instr_ready = 1'b0;
        req = 1'b1; start_addr = 8'h10;
        step(); req = 1'b0;
        step(); step();                                   // cycle 3
        req = 1'b1; start_addr = 8'h77;
        step();
        req = 1'b0;
        chk("ign_pc",    32'(pc),    32'h10);
        chk("ign_instr", 32'(instr), 32'h041);
        instr_ready = 1'b1;
        wait_ack(8, acks);
        chk("ign_acks", 32'(acks), 32'd1);
        chk("ign_pc_end", 32'(pc), 32'h11);

        // Asynchronous reset in the middle of ISSUE.
        instr_ready = 1'b0;
        req = 1'b1; start_addr = 8'h10;
        step(); req = 1'b0;
        step(); step();                                   // cycle 3
        chk("abort_pre_valid", 32'(instr_valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort_valid", 32'(instr_valid), 32'd0);
        chk("abort_busy",  32'(busy),        32'd0);
        chk("abort_ack",   32'(ack),         32'd0);
        chk("abort_pc",    32'(pc),          32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        basic_run("rerun");

        step(); step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
